// File: rtl/csr_pkg.sv
// Shared constants and types for column_sum_resolver and its column_weight_sum helper.
// Column words carry four bit groups whose bits count with weights 1, 2, 4 and 8.
package csr_pkg;

  localparam int COL_W   = 48;
  localparam int SUM_W   = 8;
  localparam int CARRY_W = 8;
  localparam int NUM_GRP = 4;

  localparam int GRP_BOUND  [NUM_GRP+1] = '{0, 6, 24, 42, 48};
  localparam int GRP_WEIGHT [NUM_GRP]   = '{1, 2, 4, 8};

  typedef enum logic [1:0] {
    ACCUM,
    FLUSH,
    LAST
  } state_e;

endpackage

// File: rtl/column_weight_sum.sv
// Combinational resolver for one compressed column word: it returns the weighted population count (0..162).
// Each group is popcounted on its own, and the group counts are then scaled and added.
module column_weight_sum
  import csr_pkg::*;
(
  input  logic [COL_W-1:0] data_i,
  output logic [SUM_W-1:0] sum_o
);

  logic [SUM_W-1:0] grp_sum [NUM_GRP];

  for (genvar gi = 0; gi < NUM_GRP; gi++) begin : g_grp
    logic [SUM_W-1:0] cnt;

    always_comb begin
      cnt = '0;
      for (int b = GRP_BOUND[gi]; b < GRP_BOUND[gi+1]; b++) begin
        cnt = cnt + SUM_W'(data_i[b]);
      end
    end

    assign grp_sum[gi] = cnt * SUM_W'(GRP_WEIGHT[gi]);
  end

  always_comb begin
    sum_o = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      sum_o = sum_o + grp_sum[g];
    end
  end

endmodule

// File: rtl/column_sum_resolver.sv
// Serial carry-propagate resolver. It takes one column per cycle and packs the result bits into OUT_W-bit words.
// Define CSR_FRAME_CNT_EN to add the frame_cnt output, which counts handshakes on the last word of each frame.
module column_sum_resolver
  import csr_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [COL_W-1:0]           s_data,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [OUT_W-1:0]           m_data,
  output logic [$clog2(OUT_W+1)-1:0] m_nbits,
  output logic                       m_last
`ifdef CSR_FRAME_CNT_EN
  ,
  output logic [15:0]                frame_cnt
`endif
);

  localparam int NB_W = $clog2(OUT_W+1);
  localparam logic [NB_W-1:0] FULL_CNT = NB_W'(OUT_W);

  state_e              state_q, state_d;
  logic [CARRY_W-1:0]  carry_q, carry_d;
  logic [2:0]          flush_cnt_q, flush_cnt_d;
  logic [OUT_W-1:0]    pack_q, pack_d;
  logic [NB_W-1:0]     pack_cnt_q, pack_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [OUT_W-1:0]    out_data_q, out_data_d;
  logic [NB_W-1:0]     out_nbits_q, out_nbits_d;
  logic                out_last_q, out_last_d;
  logic                init_q;

  logic [SUM_W-1:0]    col_sum;
  logic [SUM_W:0]      col_total;
  logic                out_free, pack_full, stall, shift_en, bit_in;

  column_weight_sum u_weight (
    .data_i (s_data),
    .sum_o  (col_sum)
  );

  assign col_total = {1'b0, col_sum} + {1'b0, carry_q};
  assign out_free  = !out_valid_q || m_ready;
  assign pack_full = (pack_cnt_q == FULL_CNT);
  assign stall     = pack_full && !out_free;
  // init_q keeps s_ready low during reset and for the first cycle after reset is released.
  assign s_ready   = init_q && (state_q == ACCUM) && !stall;

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    flush_cnt_d = flush_cnt_q;
    pack_d      = pack_q;
    pack_cnt_d  = pack_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_nbits_d = out_nbits_q;
    out_last_d  = out_last_q;
    shift_en    = 1'b0;
    bit_in      = 1'b0;

    if (out_valid_q && m_ready) out_valid_d = 1'b0;

    case (state_q)
      ACCUM: begin
        if (s_valid && s_ready) begin
          shift_en = 1'b1;
          bit_in   = col_total[0];
          carry_d  = col_total[SUM_W:1];
          if (s_last) begin
            state_d     = FLUSH;
            flush_cnt_d = 3'd7;
          end
        end
      end
      FLUSH: begin
        if (!stall) begin
          shift_en = 1'b1;
          bit_in   = carry_q[0];
          carry_d  = carry_q >> 1;
          if (flush_cnt_q == 3'd0) state_d = LAST;
          else flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
      LAST: begin
        // The pack holds every remaining bit here (1..OUT_W), so the final word is never empty.
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = pack_q;
          out_nbits_d = pack_cnt_q;
          out_last_d  = 1'b1;
          pack_d      = '0;
          pack_cnt_d  = '0;
          carry_d     = '0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase

    // A full pack is moved lazily, so the last word of a frame always leaves from LAST and carries m_last.
    if (state_q != LAST && pack_full && out_free) begin
      out_valid_d = 1'b1;
      out_data_d  = pack_q;
      out_nbits_d = FULL_CNT;
      out_last_d  = 1'b0;
      pack_d      = '0;
      pack_cnt_d  = '0;
    end

    if (shift_en) begin
      pack_d     = pack_d | (OUT_W'(bit_in) << pack_cnt_d);
      pack_cnt_d = pack_cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      carry_q     <= '0;
      flush_cnt_q <= '0;
      pack_q      <= '0;
      pack_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_nbits_q <= '0;
      out_last_q  <= 1'b0;
      init_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      flush_cnt_q <= flush_cnt_d;
      pack_q      <= pack_d;
      pack_cnt_q  <= pack_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_nbits_q <= out_nbits_d;
      out_last_q  <= out_last_d;
      init_q      <= 1'b1;
    end
  end

  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;
  assign m_nbits = out_nbits_q;
  assign m_last  = out_last_q;

`ifdef CSR_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else if (out_valid_q && m_ready && out_last_q) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_column_sum_resolver.sv
// Testbench for column_sum_resolver. It uses directed and randomized frames and checks outputs against an arithmetic reference.
// Each frame's expected value is the sum of v_i * 2^i, split into OUT_W-bit words.
module tb_column_sum_resolver;

  localparam int OUT_W = 16;
  localparam int NB_W  = $clog2(OUT_W+1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [47:0]       s_data = '0;
  logic              s_last = 1'b0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [OUT_W-1:0]  m_data;
  logic [NB_W-1:0]   m_nbits;
  logic              m_last;
`ifdef CSR_FRAME_CNT_EN
  logic [15:0]       frame_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_mode = 0;
  int stall_cycles = 0;
  int last_acc_cyc = 0;
  int first_acc = 0;
  int frames_sent = 0;

  logic [OUT_W-1:0] cap_data[$];
  logic [NB_W-1:0]  cap_nbits[$];
  logic             cap_last[$];
  int               cap_cyc[$];
  logic [OUT_W-1:0] exp_data[$];
  logic [NB_W-1:0]  exp_nbits[$];
  logic             exp_last[$];

  column_sum_resolver #(.OUT_W(OUT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_nbits (m_nbits),
    .m_last  (m_last)
`ifdef CSR_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Downstream ready: 0 = always ready, 1 = held low, 2 = random each cycle.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'b0;
      default: m_ready = 1'($urandom_range(1, 0));
    endcase
  end

  logic             hold_pend = 1'b0;
  logic [OUT_W-1:0] hold_data;
  logic [NB_W-1:0]  hold_nbits;
  logic             hold_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        checks++;
        assert (m_valid === 1'b1 && m_data === hold_data && m_nbits === hold_nbits && m_last === hold_last)
        else begin
          failures++;
          $error("FAIL hold_stable obs=%b/%h/%0d/%b exp=1/%h/%0d/%b", m_valid, m_data, m_nbits, m_last,
                 hold_data, hold_nbits, hold_last);
        end
      end
      if (m_valid && m_ready) begin
        cap_data.push_back(m_data);
        cap_nbits.push_back(m_nbits);
        cap_last.push_back(m_last);
        cap_cyc.push_back(cyc);
      end
      hold_pend  = m_valid && !m_ready;
      hold_data  = m_data;
      hold_nbits = m_nbits;
      hold_last  = m_last;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int unsigned col_val(input logic [47:0] d);
    return $countones(d[5:0]) + 2 * $countones(d[23:6]) + 4 * $countones(d[41:24]) + 8 * $countones(d[47:42]);
  endfunction

  function automatic logic [47:0] rand_col();
    logic [47:0] d;
    d = {16'($urandom), 32'($urandom)};
    case ($urandom_range(7, 0))
      0:       d = '1;
      1:       d = '0;
      2:       d = d & {16'($urandom), 32'($urandom)};
      default: ;
    endcase
    return d;
  endfunction

  task automatic expect_word(input logic [OUT_W-1:0] d, input int nb, input logic last);
    exp_data.push_back(d);
    exp_nbits.push_back(NB_W'(nb));
    exp_last.push_back(last);
  endtask

  task automatic push_model(input longint unsigned total, input int nb);
    int rem;
    for (int k = 0; k * OUT_W < nb; k++) begin
      rem = nb - k * OUT_W;
      expect_word(OUT_W'(total >> (k * OUT_W)), (rem < OUT_W) ? rem : OUT_W, rem <= OUT_W);
    end
  endtask

  task automatic send_col(input logic [47:0] d, input logic last);
    int waited = 0;
    bit acc = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!acc && waited < 3000) begin
      @(negedge clk);
      if (s_ready) acc = 1'b1;
      else begin
        waited++;
        stall_cycles++;
      end
    end
    last_acc_cyc = cyc;
    checks++;
    assert (acc) else begin
      failures++;
      $error("FAIL send_accept obs=%0d exp=1", acc);
    end
    if (acc) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [47:0] fixed, input bit rnd, input bit model);
    logic [47:0] d;
    longint unsigned total = 0;
    for (int i = 0; i < n; i++) begin
      d = rnd ? rand_col() : fixed;
      total = total + (64'(col_val(d)) << i);
      send_col(d, i == n - 1);
      if (i == 0) first_acc = last_acc_cyc;
    end
    frames_sent++;
    if (model) push_model(total, n + 8);
  endtask

  task automatic check_words(input string tag);
    int waited = 0;
    while (cap_data.size() < exp_data.size() && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    repeat (20) @(negedge clk);
    checks++;
    assert (cap_data.size() === exp_data.size()) else begin
      failures++;
      $error("FAIL %s_count obs=%0d exp=%0d", tag, cap_data.size(), exp_data.size());
    end
    for (int k = 0; k < exp_data.size() && k < cap_data.size(); k++) begin
      checks++;
      assert (cap_data[k] === exp_data[k]) else begin
        failures++;
        $error("FAIL %s_data[%0d] obs=%h exp=%h", tag, k, cap_data[k], exp_data[k]);
      end
      checks++;
      assert (cap_nbits[k] === exp_nbits[k]) else begin
        failures++;
        $error("FAIL %s_nbits[%0d] obs=%0d exp=%0d", tag, k, cap_nbits[k], exp_nbits[k]);
      end
      checks++;
      assert (cap_last[k] === exp_last[k]) else begin
        failures++;
        $error("FAIL %s_last[%0d] obs=%b exp=%b", tag, k, cap_last[k], exp_last[k]);
      end
    end
    $display("check %s: %0d words expected, %0d captured", tag, exp_data.size(), cap_data.size());
    cap_data.delete();
    cap_nbits.delete();
    cap_last.delete();
    cap_cyc.delete();
    exp_data.delete();
    exp_nbits.delete();
    exp_last.delete();
  endtask

  initial begin
    int w;
    int lat;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; assert (m_valid === 1'b0) else begin failures++; $error("FAIL rst_m_valid obs=%b exp=0", m_valid); end
    checks++; assert (m_data === '0) else begin failures++; $error("FAIL rst_m_data obs=%h exp=0", m_data); end
    checks++; assert (m_nbits === '0) else begin failures++; $error("FAIL rst_m_nbits obs=%0d exp=0", m_nbits); end
    checks++; assert (m_last === 1'b0) else begin failures++; $error("FAIL rst_m_last obs=%b exp=0", m_last); end
    checks++; assert (s_ready === 1'b0) else begin failures++; $error("FAIL rst_s_ready obs=%b exp=0", s_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; assert (s_ready === 1'b1) else begin failures++; $error("FAIL idle_s_ready obs=%b exp=1", s_ready); end
    @(posedge clk); #1;

    // Single column of weight 1, including latency to m_valid
    send_frame(1, 48'h1, 1'b0, 1'b0);
    expect_word(16'h0001, 9, 1'b1);
    w = 0;
    while (!m_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    lat = cyc - first_acc;
    checks++; assert (lat === 10) else begin failures++; $error("FAIL lat_single obs=%0d exp=10", lat); end
    check_words("t1");
    @(posedge clk); #1;

    send_frame(1, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0);
    expect_word(16'h00A2, 9, 1'b1);
    check_words("t2");
    @(posedge clk); #1;

    send_frame(2, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0);
    expect_word(16'h01E6, 10, 1'b1);
    check_words("t3");
    @(posedge clk); #1;

    send_frame(8, 48'h1, 1'b0, 1'b0);
    expect_word(16'h00FF, 16, 1'b1);
    check_words("t4");
    @(posedge clk); #1;

    // First full word latency on a streaming frame
    send_frame(20, '0, 1'b1, 1'b1);
    w = 0;
    while (cap_cyc.size() == 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    lat = (cap_cyc.size() > 0) ? cap_cyc[0] - first_acc : -1;
    checks++; assert (lat === OUT_W + 1) else begin failures++; $error("FAIL lat_first_word obs=%0d exp=%0d", lat, OUT_W + 1); end
    check_words("lat20");
    @(posedge clk); #1;

    // Downstream blocked for 30 cycles after the first word, with a second frame queued behind
    ready_mode = 1;
    stall_cycles = 0;
    fork
      begin : release_ready
        int rw;
        rw = 0;
        while (!m_valid && rw < 500) begin
          @(negedge clk);
          rw++;
        end
        repeat (30) @(posedge clk);
        ready_mode = 0;
      end
    join_none
    send_frame(24, '0, 1'b1, 1'b1);
    send_frame(20, '0, 1'b1, 1'b1);
    check_words("t5");
    checks++; assert (stall_cycles > 0) else begin failures++; $error("FAIL t5_stall obs=%0d exp=>0", stall_cycles); end
    @(posedge clk); #1;

    // Random frames under random backpressure
    ready_mode = 2;
    for (int f = 0; f < 6; f++) begin
      send_frame($urandom_range(40, 1), '0, 1'b1, 1'b1);
    end
    check_words("rnd");
    ready_mode = 0;
    @(posedge clk); #1;

`ifdef CSR_FRAME_CNT_EN
    checks++; assert (frame_cnt === 16'(frames_sent)) else begin failures++; $error("FAIL frame_cnt_pre obs=%0d exp=%0d", frame_cnt, frames_sent); end
`endif

    // Reset in the middle of a frame, then a clean frame
    for (int i = 0; i < 5; i++) send_col(rand_col(), 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; assert (m_valid === 1'b0) else begin failures++; $error("FAIL t6_rst_m_valid obs=%b exp=0", m_valid); end
    checks++; assert (s_ready === 1'b0) else begin failures++; $error("FAIL t6_rst_s_ready obs=%b exp=0", s_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; assert (cap_data.size() === 0) else begin failures++; $error("FAIL t6_stray obs=%0d exp=0", cap_data.size()); end
    @(posedge clk); #1;
    send_frame(1, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0);
    expect_word(16'h00A2, 9, 1'b1);
    check_words("t6");
`ifdef CSR_FRAME_CNT_EN
    checks++; assert (frame_cnt === 16'd1) else begin failures++; $error("FAIL frame_cnt_post obs=%0d exp=1", frame_cnt); end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
